// File: rtl/clock_div_monitor_pkg.sv
// Shared types and constants for the divided-clock receive-side monitor.
//   state_t    : lock-tracking states (SEARCH / ACQUIRE / LOCKED)
//   STALL_MULT : stall timeout expressed as a multiple of the nominal period
//   abs_diff   : unsigned absolute difference helper
package clock_div_monitor_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int unsigned STALL_MULT = 4;

  function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/clock_div_monitor_sync_edge_detect.sv
// sync_edge_detect: 3-flop synchronizer for an asynchronous level plus
// registered one-cycle rise/fall strobes in the clk domain.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   d           : asynchronous input level
//   rise_pulse  : one-cycle strobe per synchronized rising edge
//   fall_pulse  : one-cycle strobe per synchronized falling edge
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic s0;
  logic s1;
  logic s2;

  // s0/s1 resolve metastability; s1 vs s2 forms the edge comparison.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0         <= 1'b0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      s0         <= d;
      s1         <= s0;
      s2         <= s1;
      rise_pulse <= s1 & ~s2;
      fall_pulse <= ~s1 & s2;
    end
  end

endmodule

// File: rtl/clock_div_monitor.sv
// clock_div_monitor: checks an asynchronous divide-by-N clock in the clk
// domain. Measures rise-to-rise period and rise-to-fall high time, declares
// lock after LOCK_COUNT consecutive in-tolerance periods, and flags period,
// stall and (optional) duty errors.
// Optional feature: define CLOCK_DIV_MONITOR_DUTY_CHECK_EN to build the duty
// comparator; otherwise err_duty is tied low.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   clk_in      : monitored divided clock (asynchronous)
//   rise_pulse  : synchronized rising-edge strobe
//   fall_pulse  : synchronized falling-edge strobe
//   period      : last rise-to-rise interval (clk cycles)
//   high_time   : last rise-to-fall interval (clk cycles)
//   locked      : high while in LOCKED
//   err_period  : strobe on an out-of-tolerance period
//   err_stall   : strobe when no rise is seen for STALL_MULT*N cycles
//   err_duty    : strobe on out-of-range duty while locked
module clock_div_monitor
  import clock_div_monitor_pkg::*;
#(
  parameter int unsigned N          = 5,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_COUNT = 4,
  localparam int unsigned CW        = $clog2(STALL_MULT * N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_in,
  output logic          rise_pulse,
  output logic          fall_pulse,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          locked,
  output logic          err_period,
  output logic          err_stall,
  output logic          err_duty
);

  localparam int unsigned STALL_CNT = STALL_MULT * N;
  localparam int unsigned MW        = $clog2(LOCK_COUNT + 1);

  logic [CW-1:0] cnt;
  logic [MW-1:0] match;
  state_t        state;
  logic          period_ok_c;
  logic          stall_c;
  logic          lock_now_c;

  sync_edge_detect u_sync (
    .clk        (clk),
    .reset      (reset),
    .d          (clk_in),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  assign period_ok_c = (abs_diff(32'(cnt), N) <= TOL);
  // cnt is about to saturate with no rise to rescue it: a rise wins ties.
  assign stall_c     = !rise_pulse && (cnt == CW'(STALL_CNT - 1));
  assign lock_now_c  = ((32'(match) + 32'd1) == LOCK_COUNT);

  // Interval counter and measurement capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      period    <= '0;
      high_time <= '0;
    end else begin
      if (rise_pulse) begin
        period <= cnt;
        cnt    <= CW'(1);
      end else if (cnt != CW'(STALL_CNT)) begin
        cnt <= cnt + CW'(1);
      end
      if (fall_pulse) begin
        high_time <= cnt;
      end
    end
  end

  // Lock-tracking FSM with registered status and error strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEARCH;
      match      <= '0;
      locked     <= 1'b0;
      err_period <= 1'b0;
      err_stall  <= 1'b0;
    end else begin
      err_period <= 1'b0;
      err_stall  <= 1'b0;
      unique case (state)
        SEARCH: begin
          // First rise only opens a measurement window.
          if (rise_pulse) begin
            state <= ACQUIRE;
            match <= '0;
          end
        end
        ACQUIRE: begin
          if (rise_pulse) begin
            if (period_ok_c) begin
              match <= match + MW'(1);
              if (lock_now_c) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match      <= '0;
              err_period <= 1'b1;
            end
          end else if (stall_c) begin
            state     <= SEARCH;
            match     <= '0;
            err_stall <= 1'b1;
          end
        end
        LOCKED: begin
          if (rise_pulse) begin
            if (!period_ok_c) begin
              state      <= ACQUIRE;
              match      <= '0;
              locked     <= 1'b0;
              err_period <= 1'b1;
            end
          end else if (stall_c) begin
            state     <= SEARCH;
            match     <= '0;
            locked    <= 1'b0;
            err_stall <= 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          match  <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLOCK_DIV_MONITOR_DUTY_CHECK_EN
  logic duty_bad_c;

  // Compare 2*high against N so odd N needs no fractional midpoint.
  assign duty_bad_c = (abs_diff(32'({cnt, 1'b0}), N) > 32'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_duty <= 1'b0;
    end else begin
      err_duty <= fall_pulse && (state == LOCKED) && duty_bad_c;
    end
  end
`else
  assign err_duty = 1'b0;
`endif

endmodule

// File: tb/tb_clock_div_monitor.sv
// Self-checking bench for clock_div_monitor. Two instances (TOL=0 and TOL=1)
// watch the same clk_in; a time-based reference model predicts every output
// on every cycle, plus directed checks for lock, fault, stall, tolerance,
// reset and duty behaviour.
module tb_clock_div_monitor;

  localparam int unsigned N     = 5;
  localparam int unsigned LC    = 4;
  localparam int unsigned CW    = $clog2(4 * N + 1);
  localparam int          STALL = 4 * N;
  localparam int M_SEARCH = 0;
  localparam int M_ACQ    = 1;
  localparam int M_LOCKED = 2;

  logic clk = 1'b0;
  logic reset;
  logic clk_in;

  logic          rise [2];
  logic          fall [2];
  logic [CW-1:0] per  [2];
  logic [CW-1:0] hi   [2];
  logic          lck  [2];
  logic          eper [2];
  logic          estl [2];
  logic          edut [2];

  clock_div_monitor #(.N(N), .TOL(0), .LOCK_COUNT(LC)) u_t0 (
    .clk(clk), .reset(reset), .clk_in(clk_in),
    .rise_pulse(rise[0]), .fall_pulse(fall[0]), .period(per[0]), .high_time(hi[0]),
    .locked(lck[0]), .err_period(eper[0]), .err_stall(estl[0]), .err_duty(edut[0])
  );

  clock_div_monitor #(.N(N), .TOL(1), .LOCK_COUNT(LC)) u_t1 (
    .clk(clk), .reset(reset), .clk_in(clk_in),
    .rise_pulse(rise[1]), .fall_pulse(fall[1]), .period(per[1]), .high_time(hi[1]),
    .locked(lck[1]), .err_period(eper[1]), .err_stall(estl[1]), .err_duty(edut[1])
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: everything is derived from edge times.
  int   k         = 0;        // index of the last clk edge
  int   last_rst  = 0;        // edge of the most recent reset
  int   last_rise = -100000;  // edge after which the last rise strobe appeared
  logic ys [$];               // clk_in as sampled at each edge (0 under reset)
  logic x_rise, x_fall;
  int   x_period, x_high;
  int   mode [2];
  int   good [2];
  logic x_eper [2];
  logic x_estl [2];
  logic x_edut [2];

  // Observed-event trackers for directed checks.
  int obs_rise_edge  = 0;
  int obs_stall_edge = 0;
  int n_stall0       = 0;
  int n_eper0        = 0;
  int n_eper1        = 0;
  int n_duty0        = 0;

  function automatic int absd(input int a, input int b);
    return (a >= b) ? a - b : b - a;
  endfunction

  function automatic int tol_of(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  // Cycles elapsed since the last measurement restart, saturating.
  function automatic int cnt_at(input int m);
    int r;
    int v;
    r = (last_rise > last_rst) ? last_rise : last_rst;
    v = m - r;
    return (v > STALL) ? STALL : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic v);
    logic pr;
    logic pf;
    int   c;
    string nm;
    reset  = rst;
    clk_in = v;
    @(posedge clk);
    k++;
    c  = cnt_at(k - 1);
    pr = x_rise;
    pf = x_fall;
    ys.push_front(rst ? 1'b0 : v);
    if (ys.size() > 8) void'(ys.pop_back());
    if (rst) begin
      last_rst = k;
      x_rise   = 1'b0;
      x_fall   = 1'b0;
      x_period = 0;
      x_high   = 0;
      for (int i = 0; i < 2; i++) begin
        mode[i] = M_SEARCH; good[i] = 0;
        x_eper[i] = 1'b0; x_estl[i] = 1'b0; x_edut[i] = 1'b0;
      end
    end else begin
      x_rise = (k - last_rst >= 3) && ys[2] && !ys[3];
      x_fall = (k - last_rst >= 3) && !ys[2] && ys[3];
      for (int i = 0; i < 2; i++) begin
        x_eper[i] = 1'b0; x_estl[i] = 1'b0; x_edut[i] = 1'b0;
      end
      if (pf) begin
        x_high = c;
`ifdef CLOCK_DIV_MONITOR_DUTY_CHECK_EN
        for (int i = 0; i < 2; i++)
          x_edut[i] = (mode[i] == M_LOCKED) && (absd(2 * c, N) > 2);
`endif
      end
      if (pr) begin
        x_period = c;
        for (int i = 0; i < 2; i++) begin
          if (mode[i] == M_SEARCH) begin
            mode[i] = M_ACQ; good[i] = 0;
          end else if (absd(c, N) <= tol_of(i)) begin
            if (mode[i] == M_ACQ) begin
              good[i]++;
              if (good[i] == LC) mode[i] = M_LOCKED;
            end
          end else begin
            x_eper[i] = 1'b1; mode[i] = M_ACQ; good[i] = 0;
          end
        end
        last_rise = k - 1;
      end else if (c == STALL - 1) begin
        for (int i = 0; i < 2; i++) begin
          if (mode[i] != M_SEARCH) begin
            x_estl[i] = 1'b1; mode[i] = M_SEARCH; good[i] = 0;
          end
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      nm = (i == 0) ? "t0" : "t1";
      chk({nm, ".rise_pulse"}, 32'(rise[i]), 32'(x_rise));
      chk({nm, ".fall_pulse"}, 32'(fall[i]), 32'(x_fall));
      chk({nm, ".period"},     32'(per[i]),  32'(x_period));
      chk({nm, ".high_time"},  32'(hi[i]),   32'(x_high));
      chk({nm, ".locked"},     32'(lck[i]),  32'(mode[i] == M_LOCKED));
      chk({nm, ".err_period"}, 32'(eper[i]), 32'(x_eper[i]));
      chk({nm, ".err_stall"},  32'(estl[i]), 32'(x_estl[i]));
      chk({nm, ".err_duty"},   32'(edut[i]), 32'(x_edut[i]));
    end
    if (rise[0]) obs_rise_edge = k;
    if (estl[0]) begin n_stall0++; obs_stall_edge = k; end
    if (eper[0]) n_eper0++;
    if (eper[1]) n_eper1++;
    if (edut[0]) n_duty0++;
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(1'b0, v);
  endtask

  task automatic drive_period(input int p, input int h);
    hold(1'b1, h);
    hold(1'b0, p - h);
  endtask

  task automatic periods(input int cnt, input int p, input int h);
    for (int i = 0; i < cnt; i++) drive_period(p, h);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ys.push_front(1'b0);
    x_rise = 1'b0; x_fall = 1'b0; x_period = 0; x_high = 0;
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_SEARCH; good[i] = 0;
      x_eper[i] = 1'b0; x_estl[i] = 1'b0; x_edut[i] = 1'b0;
    end

    // Reset state.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("reset_locked", 32'(lck[0]), 32'd0);
    chk("reset_period", 32'(per[0]), 32'd0);

    // Lock on a steady divide-by-5.
    hold(1'b0, 2);
    n_eper0 = 0; n_stall0 = 0;
    periods(6, 5, 2);
    chk("lock_locked", 32'(lck[0]), 32'd1);
    chk("lock_period", 32'(per[0]), 32'd5);
    chk("lock_no_err", 32'(n_eper0 + n_stall0), 32'd0);

    // One stretched period, then relock.
    n_eper0 = 0;
    drive_period(7, 3);
    drive_period(5, 2);
    chk("fault_unlocked", 32'(lck[0]), 32'd0);
    periods(4, 5, 2);
    chk("fault_eper_cnt", 32'(n_eper0), 32'd1);
    chk("fault_relocked", 32'(lck[0]), 32'd1);

    // Stall, then resume.
    n_stall0 = 0;
    hold(1'b0, 30);
    chk("stall_cnt", 32'(n_stall0), 32'd1);
    chk("stall_delay", 32'(obs_stall_edge - obs_rise_edge), 32'(STALL));
    chk("stall_unlocked", 32'(lck[0]), 32'd0);
    periods(7, 5, 2);
    chk("stall_relocked", 32'(lck[0]), 32'd1);

    // Tolerance: 4/6 alternating locks only the TOL=1 instance.
    hold(1'b0, 30);
    for (int i = 0; i < 5; i++) begin
      drive_period(4, 2);
      drive_period(6, 3);
    end
    chk("tol1_locked", 32'(lck[1]), 32'd1);
    chk("tol0_unlocked", 32'(lck[0]), 32'd0);
    n_eper1 = 0;
    drive_period(7, 3);
    drive_period(5, 2);
    chk("tol1_eper_cnt", 32'(n_eper1), 32'd1);
    chk("tol1_unlocked", 32'(lck[1]), 32'd0);

    // Rise coinciding with the stall threshold, then a period at the threshold.
    periods(6, 5, 2);
    drive_period(STALL - 1, 2);
    periods(6, 5, 2);
    drive_period(STALL, 2);
    periods(6, 5, 2);

    // Reset mid-lock with clk_in high; the spurious rise must be harmless.
    chk("prereset_locked", 32'(lck[0]), 32'd1);
    hold(1'b1, 1);
    step(1'b1, 1'b1);
    chk("midreset_locked", 32'(lck[0]), 32'd0);
    chk("midreset_period", 32'(per[0]), 32'd0);
    chk("midreset_high", 32'(hi[0]), 32'd0);
    n_eper0 = 0;
    hold(1'b1, 2);
    hold(1'b0, 3);
    periods(6, 5, 2);
    chk("postreset_no_err", 32'(n_eper0), 32'd0);
    chk("postreset_locked", 32'(lck[0]), 32'd1);

    // Randomized periods and high times, with occasional long gaps.
    for (int i = 0; i < 150; i++) begin
      int p;
      int h;
      p = ($urandom_range(0, 19) == 0) ? 25 : int'($urandom_range(3, 8));
      h = int'($urandom_range(1, p - 1));
      drive_period(p, h);
    end

    // Duty: lock, then widen the high phase to 4 of 5.
    periods(7, 5, 2);
    n_duty0 = 0;
    periods(3, 5, 4);
    chk("duty_locked", 32'(lck[0]), 32'd1);
`ifdef CLOCK_DIV_MONITOR_DUTY_CHECK_EN
    chk("duty_err_cnt", 32'(n_duty0), 32'd3);
`else
    chk("duty_err_cnt", 32'(n_duty0), 32'd0);
`endif
    hold(1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_div_monitor.md
# clock_div_monitor

Receive-side checker for divided clocks generated by the clock divider (panel source/gate clocks, SDCLK, CKV). It samples an asynchronous, nominally divide-by-N clock in the `clk` domain and synchronizes it. It emits one-cycle edge strobes and measures period and high time in `clk` cycles. It declares lock after consecutive in-spec periods and flags period, stall and (optionally) duty errors for the timing-controller FSMs and the debug register bank.

## Interface
- `N`, 5: expected period of `clk_in` in `clk` cycles; ≥ 2.
- `TOL`, 0: allowed |period − N| in cycles for an in-spec period.
- `LOCK_COUNT`, 4: consecutive in-spec periods required to assert `locked`; ≥ 1.
- `CW`, derived: `$clog2(4*N+1)`; width of all counters and measurements.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high; clock `clk`.
- `clk_in` in 1: monitored divided clock; asynchronous to `clk`.
- `rise_pulse` out 1: one-cycle strobe per synchronized rising edge.
- `fall_pulse` out 1: one-cycle strobe per synchronized falling edge.
- `period` out CW: last measured rise-to-rise interval in cycles.
- `high_time` out CW: last measured rise-to-fall interval in cycles.
- `locked` out 1: high while in the LOCKED state.
- `err_period` out 1: one-cycle strobe when a measured period is out of tolerance.
- `err_stall` out 1: one-cycle strobe when no rise is seen for 4*N cycles.
- `err_duty` out 1: one-cycle strobe when duty is out of range; constant 0 unless the duty macro is defined.

## Operation
- **Synchronizer:** `s0 <= clk_in`, `s1 <= s0`, `s2 <= s1`. Registered `rise_pulse <= s1 & ~s2` and `fall_pulse <= ~s1 & s2`.
- **Counter `cnt`:**
  - On a `rise_pulse` cycle: `period <= cnt`, then `cnt <= 1`.
  - Otherwise `cnt` increments, saturating at 4*N.
  - On a `fall_pulse` cycle: `high_time <= cnt`.
  - A steady clock of period N therefore reports `period == N`.
- **In-spec check:** `period_ok` means |cnt − N| ≤ TOL, evaluated on the rise cycle.
- **FSM states:** SEARCH, ACQUIRE, LOCKED; `match` counter is 0..LOCK_COUNT.
  - SEARCH: the first rise moves to ACQUIRE with `match=0`. No check is made because the preceding interval is unknown.
  - ACQUIRE, rise with `period_ok`: `match++`. When `match+1 == LOCK_COUNT`, go to LOCKED.
  - ACQUIRE, rise without `period_ok`: `match=0`, pulse `err_period`, stay in ACQUIRE.
  - LOCKED, rise without `period_ok`: pulse `err_period`, go to ACQUIRE with `match=0`.
  - Any state except SEARCH, `cnt` reaches 4*N: pulse `err_stall` once, go to SEARCH. `cnt` stays saturated until the next rise.
- `locked` is registered and equals (state == LOCKED).
- **Simultaneous events:** a rise on the same cycle `cnt` reaches 4*N counts as a rise. The period is checked (and fails), no stall is flagged.
- **Spurious edges:** a rise seen just after reset (because `clk_in` was already high) only starts measurement from SEARCH.

## Timing
- `clk_in` edge first sampled into `s0` at edge k → strobe high in the cycle after edge k+2 (3-cycle latency), for exactly one cycle.
- `period`, `high_time`, `err_*` and the state update on the edge after the strobe cycle.
- `locked` rises 1 cycle after the qualifying rise strobe and falls 1 cycle after the failing strobe or the stall.
- **Reset values:** all outputs 0, `s0..s2` = 0, `cnt` = 0, `match` = 0, state SEARCH. Reset mid-lock drops `locked` on the next edge.
- **Sampling quantization:** measured `high_time` varies by ±1 cycle. `period` is exact for a synchronous source.

## Configuration
- `CLOCK_DIV_MONITOR_DUTY_CHECK_EN` defined:
  - On each fall while in LOCKED, if |2*high_time_new − N| > 2, pulse `err_duty`.
  - The check does not affect the state.
- Not defined: `err_duty` is tied to 0 and no duty comparator is built. `high_time` is still measured.

## Structure
- `clock_div_monitor_pkg`: state enum (SEARCH/ACQUIRE/LOCKED) and the stall multiplier constant (4).
- Sub-module `sync_edge_detect`: 3-flop synchronizer plus registered `rise_pulse`/`fall_pulse`. Reused by other asynchronous-input blocks.

## Test plan
- **Lock:** drive from the clock divider, N=5, `LOCK_COUNT=4` → `period=5` after the second rise, `locked=1` one cycle after the fifth rise strobe, no `err_*`.
- **Period fault:** after lock, stretch one period to 7 → `err_period` pulses once, `locked=0`; 4 more good periods → `locked=1` again.
- **Stall:** hold `clk_in` low after lock → `err_stall` pulses exactly 20 cycles after the last rise strobe, state SEARCH, `locked=0`; resume → relock after 5 rises.
- **Tolerance:** `TOL=1`, periods alternating 4/6 → lock achieved; a period of 7 → `err_period`.
- **Reset:** reset asserted mid-lock with `clk_in` high → next cycle all outputs 0; first post-reset rise causes no error.
- **Duty (macro defined):** N=5, high time forced to 4 cycles after lock → `err_duty` pulse, `locked` stays 1; macro undefined → `err_duty` stays 0.
